iic_eeprom_target: RTL



---
 rtl/iic_eeprom_target_pkg.sv | 19 +
 rtl/iic_bus_sync.sv | 44 ++++
 rtl/iic_eeprom_target.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/iic_eeprom_target_pkg.sv
// rtl/iic_eeprom_target_pkg.sv - shared state encoding and defaults for the I2C EEPROM target
package iic_eeprom_target_pkg;

  localparam logic [6:0] DEFAULT_DEVICE_ID = 7'h50;
  localparam int         MEM_DEPTH         = 256;

  typedef enum logic [8:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_DEV_ADDR  = 9'b0_0000_0010,
    ST_DEV_ACK   = 9'b0_0000_0100,
    ST_WORD_ADDR = 9'b0_0000_1000,
    ST_WORD_ACK  = 9'b0_0001_0000,
    ST_WR_DATA   = 9'b0_0010_0000,
    ST_WR_ACK    = 9'b0_0100_0000,
    ST_RD_DATA   = 9'b0_1000_0000,
    ST_RD_ACK    = 9'b1_0000_0000
  } state_t;

endpackage

// File: rtl/iic_bus_sync.sv
// rtl/iic_bus_sync.sv - SCL/SDA synchronisers with edge, START and STOP detection
module iic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic iic_clk,
  input  logic iic_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Reset to the idle-bus level so leaving reset never fakes an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], iic_clk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], iic_sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/iic_eeprom_target.sv
// rtl/iic_eeprom_target.sv - I2C target emulating a 256-byte 24C02-class EEPROM
module iic_eeprom_target
  import iic_eeprom_target_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID   = DEFAULT_DEVICE_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iic_clk,
  inout  wire        iic_sda,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  state_t      state;
  state_t      state_next;
  logic        scl_rise;
  logic        scl_fall;
  logic        sda_s;
  logic        start;
  logic        stop;
  logic [3:0]  cnt;
  logic [7:0]  sr;
  logic [7:0]  sr_in;
  logic [7:0]  ptr;
  logic        sda_oe;
  logic [7:0]  rd_q;
  logic        byte_done;
  logic        id_match;
  logic        mem_we;
  logic [7:0]  mem [MEM_DEPTH];

  iic_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .rst      (rst),
    .iic_clk  (iic_clk),
    .iic_sda  (iic_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start    (start),
    .stop     (stop)
  );

  // Gating with rst releases the bus in the same instant reset rises
  assign iic_sda   = (sda_oe && !rst) ? 1'b0 : 1'bz;
  assign sr_in     = {sr[6:0], sda_s};
  assign byte_done = (cnt == 4'd8);
  assign id_match  = (sr[7:1] == DEVICE_ID);
  assign mem_we    = (state == ST_WR_DATA) && scl_rise && (cnt == 4'd7) && !start && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_DEV_ADDR;
    end else begin
      case (state)
        ST_IDLE:      state_next = ST_IDLE;
        ST_DEV_ADDR:  if (scl_fall && byte_done) state_next = id_match ? ST_DEV_ACK : ST_IDLE;
        ST_DEV_ACK:   if (scl_fall) state_next = sr[0] ? ST_RD_DATA : ST_WORD_ADDR;
        ST_WORD_ADDR: if (scl_fall && byte_done) state_next = ST_WORD_ACK;
        ST_WORD_ACK:  if (scl_fall) state_next = ST_WR_DATA;
        ST_WR_DATA:   if (scl_fall && byte_done) state_next = ST_WR_ACK;
        ST_WR_ACK:    if (scl_fall) state_next = ST_WR_DATA;
        ST_RD_DATA:   if (scl_fall && byte_done) state_next = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda_s) state_next = ST_IDLE;
          else if (scl_fall)     state_next = ST_RD_DATA;
        end
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Sampling happens on scl_rise; every change to the SDA drive waits for scl_fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      sr       <= 8'd0;
      ptr      <= 8'd0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'd0;
      wr_data  <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      if (stop) begin
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        cnt    <= 4'd0;
      end else if (start) begin
        sda_oe <= 1'b0;
        cnt    <= 4'd0;
      end else begin
        case (state)
          ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              sr  <= sr_in;
              cnt <= cnt + 4'd1;
            end
            if (mem_we) begin
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= sr_in;
            end
            if (scl_fall && byte_done) begin
              if (state == ST_DEV_ADDR) begin
                sda_oe <= id_match;
                busy   <= id_match;
              end else begin
                sda_oe <= 1'b1;
                if (state == ST_WORD_ADDR) ptr <= sr;
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              cnt <= 4'd0;
              if (sr[0]) begin
                sr     <= rd_q;
                sda_oe <= ~rd_q[7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          ST_WORD_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              if (state == ST_WR_ACK) ptr <= ptr + 8'd1;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (byte_done) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 8'd1;
              end else begin
                sr     <= {sr[6:0], 1'b0};
                sda_oe <= ~sr[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) busy <= 1'b0;
              else       sr   <= rd_q;
            end
            if (scl_fall) begin
              sda_oe <= ~sr[7];
              cnt    <= 4'd0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Storage survives reset, so it has no reset branch
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= sr_in;
    rd_q <= mem[ptr];
  end

endmodule
